// File: rtl/ringosc_meas_ctrl.sv
// Multi-channel ring-oscillator frequency meter: a Clk-domain FSM gates per-channel
// saturating edge counters that run on their own oscillator, then latches the frozen counts.
module ringosc_meas_ctrl #(
  parameter int N_CH       = 8,
  parameter int CNT_W      = 16,
  parameter int GATE_W     = 12,
  parameter int SETTLE_CYC = 4,
  localparam int SEL_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [N_CH-1:0]   osc,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              start,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [GATE_W-1:0] window_count,
  output logic [CNT_W-1:0]  rd_count,
  output logic              rd_ovf
);

  localparam int SET_W = $clog2(SETTLE_CYC) + 1;
  localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;

  typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, LATCH} state_t;

  state_t                      state_q, state_d;
  logic [TMR_W-1:0]            tmr_q, tmr_d;
  logic [N_CH-1:0]             en_q, en_d;
  logic [GATE_W-1:0]           g_q, g_d;
  logic                        valid_q, valid_d;
  logic                        done_q, done_d;
  logic [GATE_W-1:0]           wc_q, wc_d;
  logic                        clr_q, clr_d;
  logic                        gate_q, gate_d;
  logic [N_CH-1:0][CNT_W-1:0]  res_q, res_d;
  logic [N_CH-1:0]             rovf_q, rovf_d;

  logic [N_CH-1:0][CNT_W-1:0]  cnt_all;
  logic [N_CH-1:0]             ovf_all;
  logic                        osc_rst;
  logic [TMR_W-1:0]            g_ext;

  assign g_ext = TMR_W'(g_q);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    en_d    = en_q;
    g_d     = g_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    wc_d    = wc_q;
    res_d   = res_q;
    rovf_d  = rovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          en_d    = ch_en;
          g_d     = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
          valid_d = 1'b0;
          tmr_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (tmr_q == TMR_W'(1)) begin
          tmr_d   = '0;
          state_d = GATE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      GATE: begin
        if (tmr_q == g_ext - TMR_W'(1)) begin
          tmr_d   = '0;
          state_d = SETTLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      SETTLE: begin
        if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
          tmr_d   = '0;
          state_d = LATCH;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      LATCH: begin
        res_d   = cnt_all;
        rovf_d  = ovf_all;
        wc_d    = g_q;
        done_d  = 1'b1;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort discards everything this run would have produced.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      tmr_d   = '0;
      done_d  = 1'b0;
      valid_d = valid_q;
      wc_d    = wc_q;
      res_d   = res_q;
      rovf_d  = rovf_q;
    end
  end

  // clr and gate are registered so the oscillator domains never see decode glitches.
  always_comb begin
    clr_d  = (state_d == CLEAR);
    gate_d = (state_d == GATE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      en_q    <= '0;
      g_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      wc_q    <= '0;
      clr_q   <= 1'b0;
      gate_q  <= 1'b0;
      res_q   <= '0;
      rovf_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      en_q    <= en_d;
      g_q     <= g_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      wc_q    <= wc_d;
      clr_q   <= clr_d;
      gate_q  <= gate_d;
      res_q   <= res_d;
      rovf_q  <= rovf_d;
    end
  end

  assign osc_rst = Reset | clr_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
      sync_d = {sync_q[0], gate_q};
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      if (sync_q[1] && en_q[i]) begin
        if (&cnt_q) ovf_d = 1'b1;
        else        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge osc[i] or posedge osc_rst) begin
      if (osc_rst) begin
        sync_q <= '0;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        sync_q <= sync_d;
        cnt_q  <= cnt_d;
        ovf_q  <= ovf_d;
      end
    end

    assign cnt_all[i] = cnt_q;
    assign ovf_all[i] = ovf_q;
  end

  always_comb begin
    rd_count = '0;
    rd_ovf   = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (rd_sel == SEL_W'(k)) begin
        rd_count = res_q[k];
        rd_ovf   = rovf_q[k];
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign valid        = valid_q;
  assign window_count = wc_q;

endmodule

// File: tb/tb_ringosc_meas_ctrl.sv
// Directed bench for ringosc_meas_ctrl: a default instance plus an 8-bit-counter
// instance share stimulus so saturation can be exercised at realistic rates.
`timescale 1ns/1ps
module tb_ringosc_meas_ctrl;

  logic        clk;
  logic        rst;
  wire  [7:0]  osc;
  logic [7:0]  ch_en;
  logic        start;
  logic        abort;
  logic [11:0] gate_cycles;
  logic [2:0]  rd_sel;

  logic        busy, done, valid;
  logic [11:0] wc;
  logic [15:0] rc;
  logic        ro;

  logic        busy8, done8, valid8;
  logic [11:0] wc8;
  logic [7:0]  rc8;
  logic        ro8;

  real half_ns [8];
  int  nasrt;
  int  nfail;

  ringosc_meas_ctrl dut (
    .Clk(clk), .Reset(rst), .osc(osc), .ch_en(ch_en), .start(start), .abort(abort),
    .gate_cycles(gate_cycles), .rd_sel(rd_sel), .busy(busy), .done(done), .valid(valid),
    .window_count(wc), .rd_count(rc), .rd_ovf(ro)
  );

  ringosc_meas_ctrl #(.CNT_W(8)) dut8 (
    .Clk(clk), .Reset(rst), .osc(osc), .ch_en(ch_en), .start(start), .abort(abort),
    .gate_cycles(gate_cycles), .rd_sel(rd_sel), .busy(busy8), .done(done8), .valid(valid8),
    .window_count(wc8), .rd_count(rc8), .rd_ovf(ro8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 8; gi++) begin : g_osc
    logic o;
    initial begin
      o = 1'b0;
      #0.3;
      forever begin
        #(half_ns[gi]);
        o = ~o;
      end
    end
    assign osc[gi] = o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
    nasrt++;
    assert (!$isunknown(obs) && obs >= 32'(lo) && obs <= 32'(hi)) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic run(input logic [7:0] en, input logic [11:0] g, input int mid_start,
                     input int abort_at, output int nb, output logic dn);
    @(negedge clk);
    ch_en = en; gate_cycles = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    while (busy === 1'b1 && nb < 4000) begin
      nb++;
      start = (nb == mid_start);
      abort = (nb == abort_at);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    dn = done;
  endtask

  initial begin
    int         nb;
    logic       dn;
    logic [15:0] keep2;
    int         p;

    nasrt = 0; nfail = 0;
    for (int k = 0; k < 8; k++) half_ns[k] = 1.25;
    rst = 1'b1; ch_en = '0; start = 1'b0; abort = 1'b0; gate_cycles = '0; rd_sel = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", valid, 0);
    chk("rst_wc", wc, 0);
    chk("rst_rc", rc, 0);
    chk("rst_ovf", ro, 0);

    // Single channel, 2.5 ns oscillator, 100-cycle window
    run(8'h01, 12'd100, -1, -1, nb, dn);
    chk("t1_busy_len", nb, 107);
    chk("t1_done", dn, 1);
    chk("t1_valid", valid, 1);
    chk("t1_wc", wc, 100);
    rd_sel = 3'd0; #1;
    chk_rng("t1_cnt0", rc, 399, 401);
    chk("t1_ovf0", ro, 0);
    rd_sel = 3'd1; #1;
    chk("t1_cnt1", rc, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_valid_sticky", valid, 1);

    // Saturation on 8-bit counter, then a short run proves clr
    run(8'h08, 12'd100, -1, -1, nb, dn);
    rd_sel = 3'd3; #1;
    chk("t2_sat_cnt", rc8, 255);
    chk("t2_sat_ovf", ro8, 1);
    chk_rng("t2_wide_cnt", rc, 399, 401);
    chk("t2_wide_ovf", ro, 0);
    rd_sel = 3'd0; #1;
    chk("t2_ch0_cleared", rc, 0);
    run(8'h08, 12'd20, -1, -1, nb, dn);
    rd_sel = 3'd3; #1;
    chk_rng("t2b_cnt", rc8, 79, 81);
    chk("t2b_ovf", ro8, 0);

    // Zero gate treated as one cycle
    run(8'h01, 12'd0, -1, -1, nb, dn);
    chk("t3_busy_len", nb, 8);
    chk("t3_wc", wc, 1);
    rd_sel = 3'd0; #1;
    chk_rng("t3_cnt", rc, 3, 5);

    // All channels, periods 2..9 ns, 300-cycle window
    for (int k = 0; k < 8; k++) half_ns[k] = real'(k + 2) / 2.0;
    repeat (2) @(negedge clk);
    run(8'hFF, 12'd300, -1, -1, nb, dn);
    chk("t4_wc", wc, 300);
    for (int k = 0; k < 8; k++) begin
      rd_sel = 3'(k); #1;
      p = k + 2;
      chk_rng($sformatf("t4_cnt%0d", k), rc, (3000 + p - 1) / p - 1, 3000 / p + 1);
    end

    // start mid-run is ignored
    run(8'hFF, 12'd100, 52, -1, nb, dn);
    chk("t5_midstart_len", nb, 107);
    chk("t5_midstart_done", dn, 1);
    rd_sel = 3'd2; #1;
    keep2 = rc;
    chk_rng("t5_cnt2", rc, 249, 251);

    // abort at cycle 50
    run(8'h04, 12'd200, -1, 50, nb, dn);
    chk("t5_abort_len", nb, 50);
    chk("t5_abort_done", dn, 0);
    chk("t5_abort_valid", valid, 0);
    chk("t5_abort_wc", wc, 100);
    rd_sel = 3'd2; #1;
    chk("t5_abort_keep", rc, {16'd0, keep2});
    @(negedge clk);
    chk("t5_abort_nodone", done, 0);

    // Reset asserted mid-GATE
    @(negedge clk);
    ch_en = 8'hFF; gate_cycles = 12'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("t6_busy_pre", busy, 1);
    rst = 1'b1; #1;
    chk("t6_busy", busy, 0);
    chk("t6_valid", valid, 0);
    chk("t6_wc", wc, 0);
    for (int k = 0; k < 8; k++) begin
      rd_sel = 3'(k); #0.1;
      chk($sformatf("t6_rc%0d", k), rc, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    run(8'h01, 12'd100, -1, -1, nb, dn);
    chk("t6_after_len", nb, 107);
    chk("t6_after_valid", valid, 1);
    rd_sel = 3'd0; #1;
    chk_rng("t6_after_cnt", rc, 499, 501);

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end

endmodule

// File: doc/ringosc_meas_ctrl.md
Name: ringosc_meas_ctrl

Overview:
- Parametrised multi-channel ring-oscillator frequency meter.
- Replaces the fixed 8×(12b+4b) free-running counter bank with a Clk-domain measurement FSM: programmable gate window, per-channel enable, saturating oscillator counters with overflow flags, and latched results read through a mux.
- Oscillator counters run in each oscillator's own domain. Results cross into Clk only after a settle interval, while the counters are static.

Parameters:
- N_CH, 8, number of oscillator channels.
- CNT_W, 16, width of each oscillator edge counter.
- GATE_W, 12, width of the gate-window length, in Clk cycles.
- SETTLE_CYC, 4, Clk cycles between gate close and result latch (≥2).

Ports:
- Clk  in  1  measurement reference clock.
- Reset  in  1  asynchronous, active-high; clears all state in both domains.
- osc  in  N_CH  raw ring-oscillator outputs; each bit is a clock.
- ch_en  in  N_CH  per-channel enable; sampled at start.
- start  in  1  one-Clk pulse that begins a measurement.
- abort  in  1  cancels the measurement in progress.
- gate_cycles  in  GATE_W  window length; sampled at start.
- rd_sel  in  clog2(N_CH)  result read select.
- busy  out  1  measurement in progress.
- done  out  1  one-cycle pulse when results are latched.
- valid  out  1  results are valid; sticky until next start, abort or Reset.
- window_count  out  GATE_W  effective window length used.
- rd_count  out  CNT_W  latched count of channel rd_sel (combinational mux).
- rd_ovf  out  1  latched overflow flag of channel rd_sel.

Behaviour:
- Reset values: FSM=IDLE; busy=0, done=0, valid=0, window_count=0; all result registers and ovf flags =0; all osc-domain counters and synchronisers =0.
- FSM states: IDLE, CLEAR, GATE, SETTLE, LATCH.
- IDLE: start=1 at a Clk edge does the following:
  - captures ch_en into en_q and gate_cycles into G_q (0 is forced to 1);
  - clears valid;
  - moves to CLEAR.
- CLEAR: lasts 2 cycles. The clr signal is asserted and asynchronously resets every osc counter, ovf flag and gate synchroniser. Then moves to GATE.
- GATE: lasts exactly G_q cycles. gate_en=1 and an internal Clk-domain window counter increments. Moves to SETTLE when window counter == G_q-1.
- SETTLE: lasts SETTLE_CYC cycles with gate_en=0, then moves to LATCH.
- LATCH: 1 cycle. Copies every osc counter and ovf flag into the Clk-domain result registers and sets window_count=G_q. Asserts done (registered, visible the following cycle) and valid=1. Returns to IDLE.
- busy=1 in every state except IDLE. Total busy length = 2+G_q+SETTLE_CYC+1 cycles.
- start while busy is ignored.
- abort while busy: returns to IDLE next cycle. valid stays 0 and results keep their old values. done is not pulsed. abort in IDLE has no effect.
- start and abort in the same IDLE cycle: start wins.
- Osc-domain channel i:
  - gate_en passes through a 2-flop synchroniser clocked by osc[i].
  - The counter increments on each osc[i] rising edge while sync_gate=1 and en_q[i]=1.
  - Saturation: at all-ones the counter holds and ovf[i] is set. ovf is sticky until clr or Reset.
- Disabled channel: the counter never increments, so its result is 0 with ovf=0.
- A stopped oscillator holds its state; its result is whatever was counted before it stopped.
- Reset mid-measurement: FSM to IDLE and all registers to reset values immediately.
- Results are only meaningful when osc[i] is toggling during GATE. SETTLE_CYC must cover 2 osc periods of the slowest channel; this is an integration constraint, not checked.

Test Plan:
- Clk 10 ns; osc[0] period 2.5 ns; ch_en=0x01; gate_cycles=100; start → busy for 107 cycles; done pulse; valid=1; rd_sel=0 gives rd_count=400±1, rd_ovf=0; window_count=100; rd_sel=1 gives 0.
- CNT_W=8 override; osc[3] period 2.5 ns; ch_en=0x08; gate_cycles=100 → rd_count[3]=255, rd_ovf=1. A second run with gate_cycles=20 → 80±1, ovf=0 (clr works).
- gate_cycles=0 → treated as 1; window_count=1; busy 8 cycles; osc 2.5 ns gives count 4±1.
- All 8 channels with periods 2,3,…,9 ns; gate_cycles=300 → each count = 3000/period ±1.
- start at G/2 of a busy run is ignored; abort at cycle 50 → busy drops next cycle; no done; valid=0; previous results unchanged.
- Reset asserted mid-GATE → busy=0, valid=0, all rd_count=0 at once. A later start completes normally.
